// File: rtl/fetch_sequencer.sv
// Fetch stage feeding a 1-cycle-latency synchronous instruction memory: drives the word
// address, pairs the returned word with its PC, and applies stall, redirect and HALT control.
module fetch_sequencer #(
  parameter int              PC_W      = 10,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     HALT_WORD = 32'hFFFF_FFFF,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic [31:0]      instr_in,
  output logic [PC_W-1:0]  imem_addr,
  output logic             fetch_valid,
  output logic [PC_W-1:0]  fetch_pc,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           r_state;
  logic [PC_W-1:0]  r_pc_q;
  logic [PC_W-1:0]  r_fetch_pc;
  logic             r_fetch_valid;
  logic             r_halted;
  logic [CNT_W-1:0] r_instr_count;

  state_t           w_state_next;
  logic [PC_W-1:0]  w_pc_q_next;
  logic [PC_W-1:0]  w_fetch_pc_next;
  logic             w_fetch_valid_next;
  logic             w_halted_next;
  logic [CNT_W-1:0] w_instr_count_next;
  logic [PC_W-1:0]  w_addr;
  logic             w_consume;
  logic             w_is_halt;

  // The only path from instr_in into control is this compare.
  assign w_is_halt = (instr_in == HALT_WORD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc_q        <= RESET_PC;
      r_fetch_pc    <= RESET_PC;
      r_fetch_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_pc_q        <= w_pc_q_next;
      r_fetch_pc    <= w_fetch_pc_next;
      r_fetch_valid <= w_fetch_valid_next;
      r_halted      <= w_halted_next;
      r_instr_count <= w_instr_count_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_pc_q_next        = r_pc_q;
    w_fetch_pc_next    = r_fetch_pc;
    w_fetch_valid_next = r_fetch_valid;
    w_halted_next      = r_halted;
    w_addr             = r_fetch_pc;
    w_consume          = 1'b0;

    if (reset) begin
      w_addr = RESET_PC;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_addr             = r_pc_q;
          w_fetch_pc_next    = r_pc_q;
          w_pc_q_next        = r_pc_q + 1'b1;
          w_fetch_valid_next = 1'b1;
          w_state_next       = ST_RUN;
        end
        ST_RUN: begin
          if (r_fetch_valid && !stall && w_is_halt) begin
            w_addr             = r_fetch_pc;
            w_fetch_valid_next = 1'b0;
            w_halted_next      = 1'b1;
            w_state_next       = ST_HALT;
            w_consume          = 1'b1;
          end else if (redirect_valid) begin
            // Redirect wins over stall: decode takes the presented word with the redirect.
            w_addr             = redirect_pc;
            w_fetch_pc_next    = redirect_pc;
            w_pc_q_next        = redirect_pc + 1'b1;
            w_fetch_valid_next = 1'b1;
            w_consume          = r_fetch_valid;
          end else if (stall) begin
            // Re-read the presented address so instr_in stays stable next cycle.
            w_addr = r_fetch_pc;
          end else begin
            w_addr             = r_pc_q;
            w_fetch_pc_next    = r_pc_q;
            w_pc_q_next        = r_pc_q + 1'b1;
            w_fetch_valid_next = 1'b1;
            w_consume          = r_fetch_valid;
          end
        end
        ST_HALT: begin
          w_addr = r_fetch_pc;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end

    w_instr_count_next = r_instr_count;
    if (w_consume && (r_instr_count != {CNT_W{1'b1}})) begin
      w_instr_count_next = r_instr_count + 1'b1;
    end
  end

  assign imem_addr   = w_addr;
  assign fetch_valid = r_fetch_valid;
  assign fetch_pc    = r_fetch_pc;
  assign halted      = r_halted;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural 1-cycle synchronous instruction memory.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic [31:0] instr_in;
  logic [9:0]  imem_addr;
  logic        fetch_valid;
  logic [9:0]  fetch_pc;
  logic        halted;
  logic [15:0] instr_count;

  logic [31:0] mem [0:1023];
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] W_A    = 32'hC0DE_0000;
  localparam logic [31:0] W_B    = 32'hC0DE_0001;
  localparam logic [31:0] W_C    = 32'hC0DE_0002;
  localparam logic [31:0] W_D    = 32'hC0DE_0003;
  localparam logic [31:0] W_HALT = 32'hFFFF_FFFF;

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_in       (instr_in),
    .imem_addr      (imem_addr),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .halted         (halted),
    .instr_count    (instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr_in <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic [9:0] pc, input logic [31:0] word,
                           input logic [15:0] cnt);
    chk({tag, "_valid"}, fetch_valid, 1);
    chk({tag, "_pc"}, fetch_pc, pc);
    chk({tag, "_instr"}, instr_in, word);
    chk({tag, "_count"}, instr_count, cnt);
    $display("fetch %s pc=%0d instr=%h count=%0d", tag, fetch_pc, instr_in, instr_count);
  endtask

  // Called at a falling edge one cycle after reset was sampled high, with reset still high.
  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, fetch_valid, 0);
    chk({tag, "_pc"}, fetch_pc, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_count"}, instr_count, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    $display("reset %s valid=%0b pc=%0d halted=%0b count=%0d addr=%0d",
             tag, fetch_valid, fetch_pc, halted, instr_count, imem_addr);
  endtask

  // Releases reset and checks cycles 1..4; returns at the falling edge showing fetch_pc=2.
  task automatic restart(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, "_c1_valid"}, fetch_valid, 0);
    chk({tag, "_c1_addr"}, imem_addr, 0);
    $display("idle %s valid=%0b addr=%0d", tag, fetch_valid, imem_addr);
    @(negedge clk);
    chk_fetch({tag, "_c2"}, 10'd0, W_A, 16'd0);
    chk({tag, "_c2_halted"}, halted, 0);
    @(negedge clk);
    chk_fetch({tag, "_c3"}, 10'd1, W_B, 16'd1);
    @(negedge clk);
    chk_fetch({tag, "_c4"}, 10'd2, W_C, 16'd2);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[6] = W_HALT;
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    repeat (2) @(negedge clk);
    chk_reset("por");

    // Reset release and straight-line fetch.
    restart("s1");
    @(negedge clk);
    chk_fetch("s1_c5", 10'd3, W_D, 16'd3);
    @(negedge clk);
    chk("s1_c6_count", instr_count, 16'd4);
    chk("s1_c6_pc", fetch_pc, 10'd4);

    // Three-cycle stall while fetch_pc=2.
    reset = 1'b1;
    @(negedge clk);
    chk_reset("s2_rst");
    restart("s2");
    stall = 1'b1;
    #1 chk("stall_addr", imem_addr, 10'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_fetch("stall_hold", 10'd2, W_C, 16'd2);
    end
    stall = 1'b0;
    @(negedge clk);
    chk_fetch("stall_rel1", 10'd3, W_D, 16'd3);
    @(negedge clk);
    chk_fetch("stall_rel2", 10'd4, 32'hC0DE_0004, 16'd4);
    @(negedge clk);
    chk_fetch("pre_redir", 10'd5, 32'hC0DE_0005, 16'd5);

    // Redirect to 100, then a redirect under stall to 200.
    redirect_valid = 1'b1;
    redirect_pc = 10'd100;
    #1 chk("redir_addr", imem_addr, 10'd100);
    @(negedge clk);
    chk_fetch("redir_tgt", 10'd100, 32'hC0DE_0064, 16'd6);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk_fetch("redir_next", 10'd101, 32'hC0DE_0065, 16'd7);
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 10'd200;
    #1 chk("redir_st_addr", imem_addr, 10'd200);
    @(negedge clk);
    chk_fetch("redir_st_tgt", 10'd200, 32'hC0DE_00C8, 16'd8);
    stall = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk_fetch("redir_st_next", 10'd201, 32'hC0DE_00C9, 16'd9);

    // Redirect near the top of the address space: wrap 1023 -> 0.
    redirect_valid = 1'b1;
    redirect_pc = 10'd1022;
    @(negedge clk);
    chk_fetch("wrap_1022", 10'd1022, 32'hC0DE_03FE, 16'd10);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk_fetch("wrap_1023", 10'd1023, 32'hC0DE_03FF, 16'd11);
    @(negedge clk);
    chk_fetch("wrap_0", 10'd0, W_A, 16'd12);
    @(negedge clk);
    chk_fetch("wrap_1", 10'd1, W_B, 16'd13);

    // Reset while running at fetch_pc=50.
    redirect_valid = 1'b1;
    redirect_pc = 10'd50;
    @(negedge clk);
    chk_fetch("at_50", 10'd50, 32'hC0DE_0032, 16'd14);
    redirect_valid = 1'b0;
    reset = 1'b1;
    #1 chk("mid_rst_addr", imem_addr, 10'd0);
    @(negedge clk);
    chk_reset("mid_rst");
    restart("s5");

    // Run into HALT at address 6 with a competing redirect.
    @(negedge clk);
    chk_fetch("h_c5", 10'd3, W_D, 16'd3);
    @(negedge clk);
    chk_fetch("h_c6", 10'd4, 32'hC0DE_0004, 16'd4);
    @(negedge clk);
    chk_fetch("h_c7", 10'd5, 32'hC0DE_0005, 16'd5);
    @(negedge clk);
    chk_fetch("h_c8", 10'd6, W_HALT, 16'd6);
    redirect_valid = 1'b1;
    redirect_pc = 10'd300;
    #1 chk("halt_addr_pre", imem_addr, 10'd6);
    @(negedge clk);
    chk("halt_halted", halted, 1);
    chk("halt_valid", fetch_valid, 0);
    chk("halt_addr", imem_addr, 10'd6);
    chk("halt_count", instr_count, 16'd7);
    $display("halt halted=%0b valid=%0b addr=%0d count=%0d", halted, fetch_valid, imem_addr, instr_count);
    for (int i = 0; i < 10; i++) begin
      stall = i[0];
      redirect_valid = i[1];
      redirect_pc = 10'd77;
      @(negedge clk);
      chk("hold_halted", halted, 1);
      chk("hold_valid", fetch_valid, 0);
      chk("hold_pc", fetch_pc, 10'd6);
      chk("hold_addr", imem_addr, 10'd6);
      chk("hold_count", instr_count, 16'd7);
      $display("hold %0d halted=%0b valid=%0b pc=%0d addr=%0d count=%0d",
               i, halted, fetch_valid, fetch_pc, imem_addr, instr_count);
    end

    // Reset while halted, then a clean restart.
    stall = 1'b0;
    redirect_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_reset("halt_rst");
    restart("s6");
    @(negedge clk);
    chk_fetch("s6_c5", 10'd3, W_D, 16'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and fetch-control stage directly upstream of the synchronous instruction memory. It generates the 10-bit word address sampled by the memory each cycle. It pairs the instruction word the memory returns one cycle later with its address and a valid flag, then hands it to decode. It applies stalls and branch/jump redirects, and stops fetching on a HALT word.

## Interface
Parameters:
- PC_W, 10: word-address width; matches the 1024-word instruction memory.
- RESET_PC, 0: first address fetched after reset.
- HALT_WORD, 32'hFFFF_FFFF: instruction encoding that halts fetch.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- stall, input, 1: decode cannot accept the presented instruction this cycle.
- redirect_valid, input, 1: decode consumes the presented instruction and requests a fetch from redirect_pc.
- redirect_pc, input, PC_W: redirect target.
- instr_in, input, 32: instruction-memory output; holds the word for the address driven on the previous cycle.
- imem_addr, output, PC_W: combinational address to the instruction memory, sampled at the next edge.
- fetch_valid, output, 1: instr_in is a live instruction at address fetch_pc.
- fetch_pc, output, PC_W: address of the presented instruction.
- halted, output, 1: HALT word retired; fetch is frozen.
- instr_count, output, CNT_W: number of instructions consumed; saturates.

## Operation
Registers:
- pc_q: next fetch address.
- fetch_pc, fetch_valid.
- state: IDLE, RUN, or HALT.
- instr_count.

An instruction is "consumed" at an edge where fetch_valid=1 and stall=0.

- **Reset** (synchronous):
  - state=IDLE, pc_q=RESET_PC, fetch_pc=RESET_PC, fetch_valid=0, halted=0, instr_count=0.
  - While reset is asserted, imem_addr=RESET_PC.
  - Reset overrides every other input.
- **IDLE** (one cycle after reset release):
  - imem_addr=pc_q.
  - Next edge: fetch_pc<=pc_q, pc_q<=pc_q+1, fetch_valid<=1, state<=RUN.
  - stall and redirect_valid are ignored.
- **RUN**: exactly one of the following applies, highest priority first.
  1. Halt, when fetch_valid && !stall && instr_in==HALT_WORD:
     - imem_addr=fetch_pc.
     - fetch_valid<=0, halted<=1, state<=HALT.
     - The HALT word counts as consumed.
     - A simultaneous redirect is ignored.
  2. Redirect, when redirect_valid (applies even if stall=1):
     - imem_addr=redirect_pc.
     - fetch_pc<=redirect_pc, pc_q<=redirect_pc+1, fetch_valid<=1.
     - The presented instruction counts as consumed if fetch_valid=1.
  3. Stall:
     - imem_addr=fetch_pc, so the memory re-reads the same word and instr_in stays stable.
     - All registers hold.
  4. Advance:
     - imem_addr=pc_q.
     - fetch_pc<=pc_q, pc_q<=pc_q+1, fetch_valid<=1.
- **HALT**:
  - imem_addr=fetch_pc; all registers hold.
  - fetch_valid=0, halted=1.
  - Exit only through reset.

Arithmetic:
- pc_q+1 and redirect_pc+1 are modulo 2^PC_W, so 1023 wraps to 0 with no flag.
- instr_count increments by 1 per consumed instruction and saturates at 2^CNT_W-1.

## Timing
- Address-to-instruction latency is 1 cycle: the address driven on imem_addr in cycle n appears on instr_in and fetch_pc in cycle n+1.
- First fetch_valid=1 occurs in the second cycle after reset deasserts, with fetch_pc=RESET_PC.
- Steady state without stalls: one instruction per cycle, fetch_pc incrementing by 1.
- A stall adds no bubble. fetch_pc, fetch_valid and instr_in stay constant for every stalled cycle; the stream resumes in the cycle after stall drops.
- A redirect adds no bubble: the target instruction is presented in the cycle after redirect_valid.
- halted rises in the cycle after the HALT word is consumed, and fetch_valid falls in that same cycle.
- imem_addr is combinational from registers and inputs. It has no path from instr_in except the HALT_WORD compare.

## Test plan
- Reset release with memory[0..3]=A,B,C,D:
  - Cycle 1: fetch_valid=0.
  - Cycles 2-5: (fetch_pc, instr_in) = (0,A), (1,B), (2,C), (3,D).
  - instr_count=4 after cycle 5.
- Stall held 3 cycles while fetch_pc=2:
  - fetch_pc=2 and instr_in=C hold for all 3 cycles; instr_count does not change.
  - After release: fetch_pc=3, then 4.
- Redirect with redirect_pc=100 while fetch_pc=5:
  - Next cycle: fetch_pc=100, valid=1, instr=mem[100].
  - Cycle after: fetch_pc=101.
  - Also apply redirect with stall=1: same response.
- Redirect to 1022 with no stalls:
  - fetch_pc sequence is 1022, 1023, 0, 1.
- HALT_WORD at address 6 with redirect_valid=1 in the same cycle:
  - Next cycle: halted=1, fetch_valid=0, imem_addr=6.
  - The redirect has no effect.
  - Values hold for 10 cycles; instr_count includes the HALT word.
- Reset asserted mid-run at fetch_pc=50 and again while halted:
  - Next cycle: all outputs at reset values and imem_addr=RESET_PC.
  - The restart sequence matches the first scenario.
